loadable_4bit_down_counter: RTL and testbench
=============================================

# loadable_4bit_down_counter

Loadable 4-bit down counter that runs from a loaded value to zero, with one-shot or auto-reload operation. It is the down-counting counterpart to the team's loadable 4-bit up counter and shares the same load/data convention. It acts as a programmable interval timer: it flags terminal count with a single-cycle pulse and reports run and done status. It sits alongside the up counter in the counter library and is driven by the same clock and synchronous reset.

## Interface
- WIDTH, 4, counter width; all arithmetic and test values are stated for 4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load strobe; captures data_in into the count and the reload register.
- data_in  input  WIDTH  value to load.
- en  input  1  count enable; when low, count and state hold.
- auto_reload  input  1  1 = periodic (reload on zero), 0 = one-shot.
- data_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse: high for exactly the cycle in which data_out first shows 0.
- busy  output  1  high in RUN state.
- done  output  1  high in DONE state (one-shot expired).

## Operation
- Internal registers: count (drives data_out), reload_reg (WIDTH), state, tc.
- States: IDLE, RUN, DONE.
- Priority at every posedge: rst > load > en-qualified counting.
- rst: data_out=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0.
- load=1, any state:
  - count<=data_in, reload_reg<=data_in, tc<=0.
  - Next state is RUN if data_in!=0, otherwise IDLE.
  - en is ignored in that cycle.
- IDLE: holds count; en has no effect.
- RUN, en=1, count>1: count<=count-1.
- RUN, en=1, count==1:
  - count<=0, tc<=1.
  - If auto_reload=1, stay in RUN.
  - If auto_reload=0, go to DONE.
- RUN, en=1, count==0 (reached only with auto_reload): count<=reload_reg, tc<=0. Stay in RUN.
- DONE: count held at 0. Exits only on load or rst.
- en=0: count, reload_reg and state hold; tc<=0.
- tc is 0 in every cycle not described above.
- No underflow wrap: the counter never decrements from 0.
- Mid-run auto_reload changes take effect at the next count==1 decision.

## Timing
- All outputs are registered and change only at the rising edge of clk.
- Load latency: load sampled at edge k, so data_out=data_in after edge k.
- One-shot with value N and en held high:
  - 0 is reached N edges after the load edge.
  - tc and done assert at that same edge.
  - busy deasserts at that same edge.
- Auto-reload with value N: period is N+1 enabled cycles (N, N-1, …, 1, 0, N, …). tc pulses once per period.
- busy and done are decoded from state and are never both high.

## Test plan
- **Reset.** Drive rst=1 for one cycle after random activity -> data_out=0, tc=0, busy=0, done=0. Drive load=1 in the same cycle as rst -> reset still wins, data_out=0.
- **One-shot.** Load 4'b1000 with en=1, auto_reload=0 ->
  - data_out steps 8,7,6,5,4,3,2,1,0 on successive edges.
  - tc is high only on the edge where data_out=0.
  - done=1 and busy=0 from that edge on; data_out stays 0 for 5 further cycles.
- **Auto-reload.** Load 4'd3 with en=1, auto_reload=1 -> data_out follows 3,2,1,0,3,2,1,0 and tc pulses every 4th cycle. Drop auto_reload to 0 during the second period -> DONE at the next 0.
- **Enable gating.** Load 4'd5 and toggle en 1,0,1,0 -> data_out follows 5,4,4,3,3. tc stays 0 and busy stays 1.
- **Load mid-count.**
  - At data_out=2, drive load=1 with data_in=4'hF and en=1 -> data_out=F, not 1.
  - Continue to 0 -> tc fires after 15 more enabled cycles.
- **Zero load.** Load 4'd0 -> state IDLE, data_out=0, busy=0, done=0, tc never asserts with en=1 for 10 cycles.

Source files
------------

// File: rtl/loadable_4bit_down_counter.sv
// Loadable down counter / programmable interval timer.
// A load captures data_in into both the live count and the reload register.
// The counter then runs down to zero and raises tc for the one cycle in which
// data_out first shows 0. After that it either stops in DONE (one-shot) or
// reloads and keeps running (auto_reload).
// busy and done are registered copies of the state decode, so they change on
// the same edge as data_out and tc.
module loadable_4bit_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             tc_r;
  logic             busy_r;
  logic             done_r;

  // Counter state machine: reset beats load, load beats enabled counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (load) begin
      // A zero load has nothing to count, so it parks in IDLE.
      count_r  <= data_in;
      reload_r <= data_in;
      tc_r     <= 1'b0;
      done_r   <= 1'b0;
      if (data_in != CNT_ZERO) begin
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
      end else begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end
    end else if (!en) begin
      // Disabled: everything holds, and a pending tc pulse is cleared.
      tc_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tc_r <= 1'b0;
        end
        ST_RUN: begin
          if (count_r > CNT_ONE) begin
            count_r <= count_r - CNT_ONE;
            tc_r    <= 1'b0;
          end else if (count_r == CNT_ONE) begin
            // Terminal count. auto_reload is sampled here, so a change
            // made mid-run takes effect at this decision.
            count_r <= CNT_ZERO;
            tc_r    <= 1'b1;
            if (auto_reload) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            // Zero in RUN happens only in periodic mode: start the next
            // period instead of wrapping below zero.
            count_r <= reload_r;
            tc_r    <= 1'b0;
          end
        end
        ST_DONE: begin
          count_r <= CNT_ZERO;
          tc_r    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= CNT_ZERO;
          tc_r    <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = count_r;
  assign tc       = tc_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_loadable_4bit_down_counter.sv
// Scoreboard bench for loadable_4bit_down_counter. Each stimulus step pushes
// the outputs expected after the next rising edge. The monitor pops one entry
// per edge and compares it against the DUT.
module tb_loadable_4bit_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] data_in;
  logic       en;
  logic       auto_reload;
  logic [3:0] data_out;
  logic       tc;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [3:0] d;
    logic       t;
    logic       b;
    logic       dn;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks_total  = 0;
  int    checks_passed = 0;

  loadable_4bit_down_counter #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data_in     (data_in),
    .en          (en),
    .auto_reload (auto_reload),
    .data_out    (data_out),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one expected entry per rising edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks_total++;
        if ({data_out, tc, busy, done} === {e.d, e.t, e.b, e.dn}) begin
          checks_passed++;
        end else begin
          $display("FAIL %s: got data_out=%h tc=%b busy=%b done=%b, expected data_out=%h tc=%b busy=%b done=%b",
                   nm, data_out, tc, busy, done, e.d, e.t, e.b, e.dn);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic r, input logic ld, input logic [3:0] d,
                       input logic e, input logic ar);
    @(negedge clk);
    rst         = r;
    load        = ld;
    data_in     = d;
    en          = e;
    auto_reload = ar;
  endtask

  task automatic step(input logic r, input logic ld, input logic [3:0] d,
                      input logic e, input logic ar,
                      input logic [3:0] xd, input logic xt, input logic xb,
                      input logic xdn, input string nm);
    exp_t x;
    drive(r, ld, d, e, ar);
    x.d  = xd;
    x.t  = xt;
    x.b  = xb;
    x.dn = xdn;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 4'd0; en = 1'b0; auto_reload = 1'b0;
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Random activity, unchecked, before the reset checks.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset, and reset beating a simultaneous load.
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset_over_load");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "idle_hold");

    // One-shot from 8.
    step(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, "oneshot_load");
    for (int i = 7; i >= 1; i--) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'(i), 1'b0, 1'b1, 1'b0, "oneshot_count");
    end
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, "oneshot_tc");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "oneshot_done_hold");
    end

    // Auto-reload from 3, dropping auto_reload in the second period.
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, "auto_load");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, "auto_p1_2");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, "auto_p1_1");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "auto_p1_tc");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, "auto_reload");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, "auto_p2_2");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, "auto_p2_1");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, "auto_to_done");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, "auto_done_hold");

    // Enable gating from 5.
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, "gate_load");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "gate_en1");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "gate_en0");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "gate_en1b");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "gate_en0b");

    // Load mid-count: reach 2, then reload with F.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, "mid_at2");
    step(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "mid_load_f");
    for (int i = 14; i >= 1; i--) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'(i), 1'b0, 1'b1, 1'b0, "mid_count");
    end
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, "mid_tc");

    // tc is cleared by a disabled cycle; reload from 1 gives period 2.
    step(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, "one_load");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "one_tc");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "one_en0_clears_tc");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, "one_reload");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "one_tc2");

    // Zero load parks in IDLE and never produces tc.
    step(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "zero_load");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "zero_idle");
    end

    // Let the monitor drain, then confirm nothing was left unchecked.
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checks_total++;
    if (exp_q.size() == 0) begin
      checks_passed++;
    end else begin
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
